pll_lock_sequencer: RTL and testbench

Controls bring-up and recovery of the board PLL that generates the 93.75/25/1 MHz clocks from the 100 MHz reference.
- Holds the PLL in reset for a minimum time, then waits for lock with a timeout and bounded retries.
- Requires the lock to be stable before releasing the downstream system reset.
- Re-sequences on loss of lock or on a software request.
- Runs on the free-running reference clock, so it works while the PLL outputs are dead.

---
 rtl/pll_lock_sequencer.sv | 130 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up/recovery sequencer on the free-running reference clock: reset hold, lock wait with
// timeout and bounded retries, lock-stability qualification, then downstream reset release.
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES     = 100,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_WIDTH           = 20
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        pll_locked_i,
    input  logic        relock_req_i,
    output logic        pll_rst_o,
    output logic        pll_ready_o,
    output logic        sys_rst_o,
    output logic        timeout_err_o,
    output logic [3:0]  retry_count_o,
    output logic [15:0] relock_count_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_HOLD_RST  = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_READY     = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]           RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [3:0]            r_retry;
    logic [15:0]           r_relock;
    logic                  r_lk_meta;
    logic                  r_lk_s;
    logic [3:0]            w_retry_inc;

    assign w_retry_inc = r_retry + 4'd1;

    // Counter free-runs by default; every state change below also clears it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= S_HOLD_RST;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_relock  <= '0;
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked_i;
            r_lk_s    <= r_lk_meta;
            r_cnt     <= r_cnt + CNT_WIDTH'(1);
            case (r_state)
                S_HOLD_RST: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (relock_req_i) begin
                        r_state <= S_HOLD_RST;
                        r_cnt   <= '0;
                        r_retry <= '0;
                    end else if (r_lk_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_retry <= w_retry_inc;
                        r_state <= (w_retry_inc == RETRY_LIMIT) ? S_FAIL : S_HOLD_RST;
                        r_cnt   <= '0;
                    end
                end
                S_STABLE: begin
                    if (relock_req_i) begin
                        r_state <= S_HOLD_RST;
                        r_cnt   <= '0;
                        r_retry <= '0;
                    end else if (!r_lk_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state <= S_READY;
                        r_cnt   <= '0;
                        r_retry <= '0;
                    end
                end
                S_READY: begin
                    // Lock loss wins over a simultaneous software request and is always counted.
                    if (!r_lk_s) begin
                        r_state <= S_HOLD_RST;
                        r_cnt   <= '0;
                        if (r_relock != 16'hFFFF) begin
                            r_relock <= r_relock + 16'd1;
                        end
                    end else if (relock_req_i) begin
                        r_state <= S_HOLD_RST;
                        r_cnt   <= '0;
                    end
                end
                S_FAIL: begin
                    if (relock_req_i) begin
                        r_state <= S_HOLD_RST;
                        r_cnt   <= '0;
                        r_retry <= '0;
                    end
                end
                default: begin
                    r_state <= S_HOLD_RST;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pll_rst_o      = (r_state == S_HOLD_RST) || (r_state == S_FAIL);
    assign pll_ready_o    = (r_state == S_READY);
    assign sys_rst_o      = !pll_ready_o;
    assign timeout_err_o  = (r_state == S_FAIL);
    assign retry_count_o  = r_retry;
    assign relock_count_o = r_relock;
    assign state_o        = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus randomized traffic against a timeline model.
module tb_pll_lock_sequencer;

    localparam int HOLD = 4;
    localparam int TMO  = 20;
    localparam int STB  = 8;
    localparam int MAXR = 2;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked_i = 1'b0;
    logic        relock_req_i = 1'b0;
    logic        pll_rst_o, pll_ready_o, sys_rst_o, timeout_err_o;
    logic [3:0]  retry_count_o;
    logic [15:0] relock_count_o;
    logic [2:0]  state_o;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: phase number, cycles spent in the phase, counters, raw-lock history.
    int m_phase = 0;
    int m_age = 0;
    int m_retry = 0;
    int m_relock = 0;
    bit m_hist0 = 0;
    bit m_hist1 = 0;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES(HOLD), .LOCK_TIMEOUT_CYCLES(TMO), .LOCK_STABLE_CYCLES(STB),
        .MAX_RETRIES(MAXR), .CNT_WIDTH(20)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked_i(pll_locked_i), .relock_req_i(relock_req_i),
        .pll_rst_o(pll_rst_o), .pll_ready_o(pll_ready_o), .sys_rst_o(sys_rst_o),
        .timeout_err_o(timeout_err_o), .retry_count_o(retry_count_o),
        .relock_count_o(relock_count_o), .state_o(state_o)
    );

    always #5 refclk = ~refclk;

    task automatic model_edge(input bit lk, input bit req, input bit r);
        bit seen;
        int nxt;
        if (r) begin
            m_phase = 0; m_age = 0; m_retry = 0; m_relock = 0; m_hist0 = 0; m_hist1 = 0;
            return;
        end
        seen = m_hist1;  // the lock value the sequencer acts on was sampled two edges ago
        m_hist1 = m_hist0;
        m_hist0 = lk;
        nxt = m_phase;
        case (m_phase)
            0: if (m_age + 1 >= HOLD) nxt = 1;
            1: begin
                if (req) begin nxt = 0; m_retry = 0; end
                else if (seen) nxt = 2;
                else if (m_age + 1 >= TMO) begin
                    m_retry = m_retry + 1;
                    nxt = (m_retry == MAXR) ? 4 : 0;
                end
            end
            2: begin
                if (req) begin nxt = 0; m_retry = 0; end
                else if (!seen) nxt = 1;
                else if (m_age + 1 >= STB) begin nxt = 3; m_retry = 0; end
            end
            3: begin
                if (!seen) begin nxt = 0; if (m_relock < 65535) m_relock = m_relock + 1; end
                else if (req) nxt = 0;
            end
            default: if (req) begin nxt = 0; m_retry = 0; end
        endcase
        m_age = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
    endtask

    task automatic step(input bit lk, input bit req, input bit r);
        pll_locked_i = lk;
        relock_req_i = req;
        rst = r;
        @(posedge refclk);
        model_edge(lk, req, r);
        @(negedge refclk);
    endtask

    task automatic test_reset();
        repeat (3) step(0, 0, 1);
        n_total++; if (state_o !== 3'd0) $display("FAIL reset_state got %0d want 0", state_o); else n_pass++;
        n_total++; if ({pll_rst_o, sys_rst_o, pll_ready_o, timeout_err_o} !== 4'b1100)
            $display("FAIL reset_outputs got %b want 1100", {pll_rst_o, sys_rst_o, pll_ready_o, timeout_err_o}); else n_pass++;
        n_total++; if ({retry_count_o, relock_count_o} !== 20'd0)
            $display("FAIL reset_counts got %0d/%0d want 0/0", retry_count_o, relock_count_o); else n_pass++;
    endtask

    task automatic test_bringup();
        int n;
        n = 0;
        while (pll_rst_o === 1'b1 && n < 50) begin step(0, 0, 0); n++; end
        n_total++; if (n != HOLD) $display("FAIL bringup_hold got %0d want %0d", n, HOLD); else n_pass++;
        repeat (4) step(0, 0, 0);
        step(1, 0, 0);               // lock first sampled at this edge
        step(1, 0, 0); step(1, 0, 0);
        n_total++; if (state_o !== 3'd2) $display("FAIL bringup_stable got %0d want 2", state_o); else n_pass++;
        n = 2;
        while (pll_ready_o !== 1'b1 && n < 50) begin step(1, 0, 0); n++; end
        n_total++; if (n != 2 + STB) $display("FAIL bringup_latency got %0d want %0d", n, 2 + STB); else n_pass++;
        n_total++; if (sys_rst_o !== 1'b0 || retry_count_o !== 4'd0)
            $display("FAIL bringup_release got sys_rst=%b retry=%0d want 0/0", sys_rst_o, retry_count_o); else n_pass++;
    endtask

    task automatic test_glitch();
        int n;
        bit seen_wait;
        step(1, 1, 0);
        n_total++; if (state_o !== 3'd0 || relock_count_o !== 16'd0)
            $display("FAIL req_in_ready got state=%0d relock=%0d want 0/0", state_o, relock_count_o); else n_pass++;
        n = 0;
        while (state_o !== 3'd2 && n < 50) begin step(1, 0, 0); n++; end
        repeat (3) step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);               // re-lock sampled here
        n = 0; seen_wait = 0;
        while (pll_ready_o !== 1'b1 && n < 50) begin
            step(1, 0, 0); n++;
            if (state_o === 3'd1) seen_wait = 1;
        end
        n_total++; if (!seen_wait) $display("FAIL glitch_wait got no WAIT_LOCK want WAIT_LOCK"); else n_pass++;
        n_total++; if (n != 2 + STB) $display("FAIL glitch_latency got %0d want %0d", n, 2 + STB); else n_pass++;
        n_total++; if (retry_count_o !== 4'd0) $display("FAIL glitch_retry got %0d want 0", retry_count_o); else n_pass++;
    endtask

    task automatic test_timeout();
        int n;
        bit held;
        step(0, 1, 0);
        n = 0;
        while (state_o !== 3'd4 && n < 200) begin step(0, 0, 0); n++; end
        n_total++; if (n != MAXR * (HOLD + TMO)) $display("FAIL timeout_cycles got %0d want %0d", n, MAXR * (HOLD + TMO)); else n_pass++;
        n_total++; if ({timeout_err_o, pll_rst_o, retry_count_o} !== {1'b1, 1'b1, 4'(MAXR)})
            $display("FAIL timeout_outputs got err=%b prst=%b retry=%0d want 1/1/%0d", timeout_err_o, pll_rst_o, retry_count_o, MAXR); else n_pass++;
        held = 1;
        repeat (100) begin
            step(1'($urandom_range(0, 1)), 0, 0);
            if (state_o !== 3'd4 || pll_rst_o !== 1'b1 || timeout_err_o !== 1'b1) held = 0;
        end
        n_total++; if (!held) $display("FAIL fail_hold got exit want held 100 cycles"); else n_pass++;
    endtask

    task automatic test_recovery();
        int n;
        repeat (3) step(1, 0, 0);
        step(1, 1, 0);
        n_total++; if (timeout_err_o !== 1'b0 || retry_count_o !== 4'd0 || state_o !== 3'd0)
            $display("FAIL recover_exit got err=%b retry=%0d state=%0d want 0/0/0", timeout_err_o, retry_count_o, state_o); else n_pass++;
        n = 1;
        while (pll_ready_o !== 1'b1 && n < 50) begin step(1, 0, 0); n++; end
        n_total++; if (n != HOLD + 2 + STB) $display("FAIL recover_latency got %0d want %0d", n, HOLD + 2 + STB); else n_pass++;
    endtask

    task automatic test_loss();
        int n;
        bit early;
        step(0, 0, 0);
        early = sys_rst_o;
        step(0, 0, 0);
        early = early | sys_rst_o;
        step(1, 0, 0);
        n_total++; if (early !== 1'b0 || sys_rst_o !== 1'b1)
            $display("FAIL loss_sys_rst got early=%b at2=%b want 0/1", early, sys_rst_o); else n_pass++;
        n_total++; if (relock_count_o !== 16'd1) $display("FAIL loss_count got %0d want 1", relock_count_o); else n_pass++;
        n = 0;
        while (pll_rst_o === 1'b1 && n < 20) begin step(1, 0, 0); n++; end
        n_total++; if (n != HOLD) $display("FAIL loss_pll_rst got %0d want %0d", n, HOLD); else n_pass++;
        n = 0;
        while (pll_ready_o !== 1'b1 && n < 50) begin step(1, 0, 0); n++; end
        n_total++; if (pll_ready_o !== 1'b1) $display("FAIL loss_relock got ready=%b want 1", pll_ready_o); else n_pass++;
        step(0, 0, 0); step(0, 0, 0);
        step(1, 1, 0);               // request lands on the same cycle the loss is acted on
        n_total++; if (relock_count_o !== 16'd2 || state_o !== 3'd0)
            $display("FAIL loss_with_req got relock=%0d state=%0d want 2/0", relock_count_o, state_o); else n_pass++;
        n = 0;
        while (pll_ready_o !== 1'b1 && n < 50) begin step(1, 0, 0); n++; end
    endtask

    task automatic test_reset_mid_stable();
        int n;
        step(1, 1, 0);
        n = 0;
        while (state_o !== 3'd2 && n < 50) begin step(1, 0, 0); n++; end
        step(1, 0, 0);
        step(1, 0, 1);
        n_total++; if ({state_o, pll_rst_o, sys_rst_o, pll_ready_o} !== {3'd0, 3'b110})
            $display("FAIL midreset_outputs got state=%0d prst=%b srst=%b rdy=%b want 0/1/1/0", state_o, pll_rst_o, sys_rst_o, pll_ready_o); else n_pass++;
        n_total++; if (relock_count_o !== 16'd0 || retry_count_o !== 4'd0)
            $display("FAIL midreset_counts got %0d/%0d want 0/0", relock_count_o, retry_count_o); else n_pass++;
        step(1, 0, 0);
    endtask

    task automatic test_random();
        bit lk, req, r;
        logic [26:0] got, want;
        lk = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) lk = ~lk;
            req = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 699) == 0);
            step(lk, req, r);
            got = {state_o, pll_rst_o, pll_ready_o, sys_rst_o, timeout_err_o, retry_count_o, relock_count_o};
            want = {3'(m_phase), (m_phase == 0 || m_phase == 4), (m_phase == 3), (m_phase != 3),
                    (m_phase == 4), 4'(m_retry), 16'(m_relock)};
            n_total++;
            if (got !== want) $display("FAIL random_cycle%0d got %h want %h", i, got, want);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_glitch();
        test_timeout();
        test_recovery();
        test_loss();
        test_reset_mid_stable();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
